// File: rtl/req_button_capture_pkg.sv
// req_button_capture_pkg: shared sizing for the button capture front end
package req_button_capture_pkg;
    localparam int N_FLOORS        = 8;
    localparam int FLOOR_W         = $clog2(N_FLOORS);
    localparam int DEB_CYCLES_DEF  = 50000;
    localparam int DEB_SAMPLES_DEF = 3;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronize, sample-debounce and edge-detect one raw button
module btn_debounce
    import req_button_capture_pkg::*;
#(
    parameter int SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic sample_tick,
    output logic press
);
    logic s1, s2, level;
    logic [SAMPLES-1:0] hist, hist_n;
    always_comb hist_n = sample_tick ? SAMPLES'({hist, s2}) : hist;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            hist  <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            hist  <= hist_n;
            level <= &hist_n ? 1'b1 : ~|hist_n ? 1'b0 : level;
            press <= ~level & &hist_n;
        end
    end
endmodule

// File: rtl/req_button_capture.sv
// req_button_capture: debounced button events and latched per-floor requests
module req_button_capture
    import req_button_capture_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] out_btn_raw,
    input  logic [N_FLOORS-1:0] in_btn_raw,
    input  logic                open_btn_raw,
    input  logic                close_btn_raw,
    input  logic                serve_valid,
    input  logic [FLOOR_W-1:0]  serve_floor,
    output logic [N_FLOORS-1:0] out_req,
    output logic [N_FLOORS-1:0] in_req,
    output logic                open_pulse,
    output logic                close_pulse,
    output logic                sample_tick
);
    localparam int NC = 2 * N_FLOORS + 2;
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic [NC-1:0] raw, ev;
    logic [N_FLOORS-1:0] clr;
    assign raw         = {close_btn_raw, open_btn_raw, in_btn_raw, out_btn_raw};
    assign sample_tick = cnt == CW'(DEB_CYCLES - 1);
    assign open_pulse  = ev[2*N_FLOORS];
    assign close_pulse = ev[2*N_FLOORS+1];
    always_ff @(posedge clk) cnt <= reset || sample_tick ? '0 : cnt + CW'(1);
    // out-of-range floors match no index, so they clear nothing
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_FLOORS; i++) clr[i] = serve_valid && serve_floor == FLOOR_W'(i);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_req <= '0;
            in_req  <= '0;
        end else begin
            out_req <= (out_req | ev[N_FLOORS-1:0]) & ~clr;
            in_req  <= (in_req | ev[2*N_FLOORS-1:N_FLOORS]) & ~clr;
        end
    end
    for (genvar c = 0; c < NC; c++) begin : g_deb
        btn_debounce #(.SAMPLES(DEB_SAMPLES)) u_deb (
            .clk         (clk),
            .reset       (reset),
            .raw         (raw[c]),
            .sample_tick (sample_tick),
            .press       (ev[c])
        );
    end
endmodule

// File: tb/tb_req_button_capture.sv
// tb_req_button_capture: scenario and randomized checks against a behavioural model
module tb_req_button_capture;
    import req_button_capture_pkg::*;
    localparam int DC = 4;
    localparam int DS = 3;
    localparam int NC = 2 * N_FLOORS + 2;
    logic clk = 1'b0, reset = 1'b1;
    logic [N_FLOORS-1:0] out_btn_raw = '0, in_btn_raw = '0;
    logic open_btn_raw = 1'b0, close_btn_raw = 1'b0, serve_valid = 1'b0;
    logic [FLOOR_W-1:0] serve_floor = '0;
    logic [N_FLOORS-1:0] out_req, in_req;
    logic open_pulse, close_pulse, sample_tick;
    int n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    req_button_capture #(.DEB_CYCLES(DC), .DEB_SAMPLES(DS)) dut (
        .clk           (clk),
        .reset         (reset),
        .out_btn_raw   (out_btn_raw),
        .in_btn_raw    (in_btn_raw),
        .open_btn_raw  (open_btn_raw),
        .close_btn_raw (close_btn_raw),
        .serve_valid   (serve_valid),
        .serve_floor   (serve_floor),
        .out_req       (out_req),
        .in_req        (in_req),
        .open_pulse    (open_pulse),
        .close_pulse   (close_pulse),
        .sample_tick   (sample_tick)
    );

    // Model: raw seen two edges late, sampled every DC cycles; a level changes
    // once a run of DS equal samples is seen; requests are set/clear bit flags.
    logic [NC-1:0] m_r1 = '0, m_r2 = '0, m_lvl = '0, m_ev = '0, m_last = '0;
    int m_run [NC];
    int m_cyc = 0;
    logic [N_FLOORS-1:0] m_out = '0, m_in = '0;
    logic [2*N_FLOORS+2:0] act_vec, exp_vec;
    assign act_vec = {out_req, in_req, open_pulse, close_pulse, sample_tick};
    assign exp_vec = {m_out, m_in, m_ev[NC-2], m_ev[NC-1], (m_cyc % DC) == DC - 1};

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_r1 = '0; m_r2 = '0; m_lvl = '0; m_ev = '0; m_last = '0;
            m_out = '0; m_in = '0; m_cyc = 0;
            foreach (m_run[c]) m_run[c] = DS;
        end else begin
            for (int f = 0; f < N_FLOORS; f++)
                if (serve_valid && serve_floor == f) begin
                    m_out[f] = 1'b0;
                    m_in[f]  = 1'b0;
                end else begin
                    m_out[f] = m_out[f] | m_ev[f];
                    m_in[f]  = m_in[f] | m_ev[N_FLOORS+f];
                end
            m_ev = '0;
            if (m_cyc % DC == DC - 1)
                for (int c = 0; c < NC; c++) begin
                    if (m_r2[c] == m_last[c]) m_run[c]++;
                    else begin
                        m_last[c] = m_r2[c];
                        m_run[c] = 1;
                    end
                    if (m_run[c] >= DS && m_lvl[c] != m_r2[c]) begin
                        m_ev[c]  = m_r2[c];
                        m_lvl[c] = m_r2[c];
                    end
                end
            m_cyc++;
            m_r2 = m_r1;
            m_r1 = {close_btn_raw, open_btn_raw, in_btn_raw, out_btn_raw};
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        out_btn_raw = '0; in_btn_raw = '0;
        open_btn_raw = 1'b0; close_btn_raw = 1'b0; serve_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int last_tick = -1, opens = 0, set_cyc = -1;
        reset = 1'b1;
        out_btn_raw = '1; in_btn_raw = '1; open_btn_raw = 1'b1; close_btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (act_vec !== '0) $display("FAIL reset_hold got=%h exp=0", act_vec); else n_pass++;
        end
        reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            n_checks++; if (act_vec !== exp_vec) $display("FAIL reset_model cyc=%0d got=%h exp=%h", i, act_vec, exp_vec); else n_pass++;
            if (sample_tick) begin
                if (last_tick >= 0) begin
                    n_checks++; if (i - last_tick != DC) $display("FAIL tick_period got=%0d exp=%0d", i - last_tick, DC); else n_pass++;
                end
                last_tick = i;
            end
            opens += int'(open_pulse);
            if (set_cyc < 0 && (out_req != 0 || in_req != 0)) begin
                set_cyc = i;
                n_checks++; if ({out_req, in_req} !== '1) $display("FAIL reset_req_together got=%h exp=ffff", {out_req, in_req}); else n_pass++;
            end
        end
        n_checks++; if (set_cyc != DS * DC) $display("FAIL reset_req_delay got=%0d exp=%0d", set_cyc, DS * DC); else n_pass++;
        n_checks++; if (opens != 1) $display("FAIL reset_open_count got=%0d exp=1", opens); else n_pass++;
    endtask

    task automatic test_clean_press();
        int first = -1;
        do_reset();
        in_btn_raw[5] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            serve_valid = 1'b0;
            n_checks++; if (act_vec !== exp_vec) $display("FAIL press_model cyc=%0d got=%h exp=%h", i, act_vec, exp_vec); else n_pass++;
            if (first < 0 && in_req[5]) first = i + 1;
            if (i == 19) begin
                n_checks++; if (in_req !== 8'h20) $display("FAIL press_set got=%h exp=20", in_req); else n_pass++;
                serve_valid = 1'b1;
                serve_floor = 3'd5;
            end
        end
        n_checks++; if (first < 1 || first > 15) $display("FAIL press_latency got=%0d exp=<=15", first); else n_pass++;
        n_checks++; if (in_req !== 8'h00) $display("FAIL press_held_once got=%h exp=00", in_req); else n_pass++;
        in_btn_raw[5] = 1'b0;
        repeat (16) @(negedge clk);
        in_btn_raw[5] = 1'b1;
        repeat (20) @(negedge clk);
        in_btn_raw[5] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (act_vec !== exp_vec) $display("FAIL repress_model cyc=%0d got=%h exp=%h", i, act_vec, exp_vec); else n_pass++;
        end
        n_checks++; if (in_req !== 8'h20) $display("FAIL press_sticky got=%h exp=20", in_req); else n_pass++;
    endtask

    task automatic test_glitch();
        do_reset();
        out_btn_raw[2] = 1'b1;
        repeat (DC) @(negedge clk);
        out_btn_raw[2] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_checks++; if (out_req !== 8'h00 || act_vec !== exp_vec) $display("FAIL glitch cyc=%0d got=%h exp=%h", i, act_vec, exp_vec); else n_pass++;
        end
    endtask

    task automatic test_serve();
        do_reset();
        out_btn_raw = 8'h24;
        in_btn_raw  = 8'h04;
        repeat (20) @(negedge clk);
        out_btn_raw = '0;
        in_btn_raw  = '0;
        repeat (16) @(negedge clk);
        n_checks++; if ({out_req, in_req} !== 16'h2404) $display("FAIL serve_setup got=%h exp=2404", {out_req, in_req}); else n_pass++;
        serve_valid = 1'b1; serve_floor = 3'd3;
        @(negedge clk);
        serve_valid = 1'b0;
        n_checks++; if ({out_req, in_req} !== 16'h2404) $display("FAIL serve_other_floor got=%h exp=2404", {out_req, in_req}); else n_pass++;
        serve_valid = 1'b1; serve_floor = 3'd2;
        @(negedge clk);
        serve_valid = 1'b0;
        n_checks++; if ({out_req, in_req} !== 16'h2000) $display("FAIL serve_clear got=%h exp=2000", {out_req, in_req}); else n_pass++;
        n_checks++; if (act_vec !== exp_vec) $display("FAIL serve_model got=%h exp=%h", act_vec, exp_vec); else n_pass++;
    endtask

    task automatic test_collision();
        for (int k = 0; k < 2; k++) begin
            int waited = 0;
            do_reset();
            in_btn_raw[1] = 1'b1;
            while (!m_ev[N_FLOORS+1] && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            n_checks++; if (waited >= 40) $display("FAIL collide_wait got=%0d exp=<40", waited); else n_pass++;
            serve_valid = 1'b1;
            serve_floor = k == 0 ? 3'd1 : 3'd0;
            @(negedge clk);
            serve_valid = 1'b0;
            n_checks++; if (in_req !== (k == 0 ? 8'h00 : 8'h02)) $display("FAIL collide_%0d got=%h exp=%h", k, in_req, k == 0 ? 8'h00 : 8'h02); else n_pass++;
            n_checks++; if (act_vec !== exp_vec) $display("FAIL collide_model_%0d got=%h exp=%h", k, act_vec, exp_vec); else n_pass++;
            in_btn_raw[1] = 1'b0;
        end
    endtask

    task automatic test_door();
        int opens = 0, closes = 0, both = 0;
        do_reset();
        open_btn_raw = 1'b1;
        repeat (100) begin @(negedge clk); opens += int'(open_pulse); end
        n_checks++; if (opens != 1) $display("FAIL door_hold got=%0d exp=1", opens); else n_pass++;
        open_btn_raw = 1'b0;
        repeat (20) @(negedge clk);
        opens = 0;
        open_btn_raw = 1'b1;
        repeat (30) begin @(negedge clk); opens += int'(open_pulse); end
        n_checks++; if (opens != 1) $display("FAIL door_repress got=%0d exp=1", opens); else n_pass++;
        open_btn_raw = 1'b0;
        repeat (20) @(negedge clk);
        opens = 0;
        open_btn_raw = 1'b1; close_btn_raw = 1'b1;
        repeat (30) begin
            @(negedge clk);
            opens += int'(open_pulse);
            closes += int'(close_pulse);
            both += int'(open_pulse & close_pulse);
            n_checks++; if (act_vec !== exp_vec) $display("FAIL door_model got=%h exp=%h", act_vec, exp_vec); else n_pass++;
        end
        n_checks++; if (both != 1 || opens != 1 || closes != 1) $display("FAIL door_both got=%0d/%0d/%0d exp=1/1/1", both, opens, closes); else n_pass++;
        open_btn_raw = 1'b0; close_btn_raw = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            n_checks++; if (act_vec !== exp_vec) $display("FAIL random cyc=%0d got=%h exp=%h", i, act_vec, exp_vec); else n_pass++;
            if ($urandom_range(0, 15) == 0) out_btn_raw[$urandom_range(0, N_FLOORS - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) in_btn_raw[$urandom_range(0, N_FLOORS - 1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) open_btn_raw = ~open_btn_raw;
            if ($urandom_range(0, 31) == 0) close_btn_raw = ~close_btn_raw;
            serve_valid = $urandom_range(0, 9) == 0;
            serve_floor = FLOOR_W'($urandom_range(0, N_FLOORS - 1));
        end
        serve_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_serve();
        test_collision();
        test_door();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/req_button_capture.md
Name: req_button_capture

Overview:
Input-side front end of the elevator controller: synchronizes and debounces the raw hall-call, car-call and door buttons. Converts each press into a single-cycle event and holds per-floor request bits until the controller reports that floor as served. Its latched outputs drive the out_req/in_req request vectors and the open/close door button inputs of the main elevator module. It is the counterpart of the display/lamp output path.

Parameters:
N_FLOORS, 8, number of floors; width of each request vector
FLOOR_W, 3, width of serve_floor; equals clog2(N_FLOORS)
DEB_CYCLES, 50000, clk cycles between debounce samples (1 ms at 50 MHz)
DEB_SAMPLES, 3, consecutive equal samples required to change a debounced level

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
out_btn_raw  input  N_FLOORS  raw hall-call buttons, 1 = pressed, asynchronous
in_btn_raw  input  N_FLOORS  raw car-call buttons, 1 = pressed, asynchronous
open_btn_raw  input  1  raw door-open button, asynchronous
close_btn_raw  input  1  raw door-close button, asynchronous
serve_valid  input  1  one-cycle strobe from FSM: floor serve_floor has been served (door opened there)
serve_floor  input  FLOOR_W  floor index qualified by serve_valid
out_req  output  N_FLOORS  latched hall-call requests
in_req  output  N_FLOORS  latched car-call requests
open_pulse  output  1  one-cycle pulse on debounced door-open press
close_pulse  output  1  one-cycle pulse on debounced door-close press
sample_tick  output  1  one-cycle debounce sample strobe (for bench/observation)

Behaviour:
- Reset (synchronous, clk edge with reset=1): prescaler=0; all sync flops, sample shift registers and debounced levels=0; out_req=0, in_req=0, open_pulse=0, close_pulse=0, sample_tick=0. Reset asserted mid-debounce discards partial history. A button held through reset release must collect DEB_SAMPLES fresh samples before producing a press.
- Prescaler: counts 0..DEB_CYCLES-1 and wraps. sample_tick=1 for exactly the cycle in which count==DEB_CYCLES-1.
- Each of the 2*N_FLOORS+2 channels:
  - 2-flop synchronizer.
  - On sample_tick, shift the synced bit into a DEB_SAMPLES-bit history.
  - Debounced level becomes 1 when the history is all ones and 0 when it is all zeros; otherwise it holds.
  - press event = debounced level 0->1 transition, registered, exactly one clk cycle wide. Release produces no event.
- Latency: a clean press stable before tick k produces its event in the cycle after tick k+DEB_SAMPLES-1. That is at most DEB_SAMPLES*DEB_CYCLES+3 cycles from the raw edge. Glitches shorter than DEB_SAMPLES-1 sample periods produce no event.
- Request latch, per floor i:
  - out_req[i] sets on an out press event for i.
  - out_req[i] clears when serve_valid=1 and serve_floor==i. in_req behaves identically.
  - Set and clear in the same cycle: clear wins; the press is dropped, since the car is already at that floor.
  - Setting an already-set bit has no effect.
  - serve_valid clears both out_req[i] and in_req[i].
  - serve_floor >= N_FLOORS: no effect.
- open_pulse/close_pulse are direct press events and are not latched. Both may be 1 in the same cycle; downstream arbitrates.
- A held button yields exactly one event; re-press requires a debounced release first.
- Multiple simultaneous presses on different channels all register in the same cycle.

Decomposition:
- Shared package: N_FLOORS, FLOOR_W, default DEB_CYCLES, DEB_SAMPLES.
- Sub-module btn_debounce (sync + history + level + edge event, input sample_tick). Instantiated 2*N_FLOORS+2 times.
- Top module holds the prescaler and the request latch registers.

Test Plan (bench overrides DEB_CYCLES=4, DEB_SAMPLES=3):
- Reset behaviour: hold reset 5 cycles with all buttons pressed, then release. All outputs are 0 during reset. out_req/in_req stay 0 until 3 ticks after release, then all bits become 1 together. sample_tick period is 4 cycles.
- Clean press: in_btn_raw[5]=1 held for 40 cycles. in_req becomes 8'h20 within 15 cycles and stays set after release. Only one internal event occurs.
- Glitch rejection: out_btn_raw[2] is high for exactly 1 sample period (4 cycles), then low. out_req stays 8'h00.
- Serve clear: with out_req=8'h24 and in_req=8'h04, pulse serve_valid with serve_floor=2. Next cycle out_req=8'h20 and in_req=8'h00. serve_floor=3 instead leaves both unchanged.
- Collision: align an in_btn_raw[1] press event with serve_valid/serve_floor=1 in the same cycle. in_req[1] stays 0. The same press aligned with serve_floor=0 sets in_req[1]=1.
- Door buttons: hold open_btn_raw for 100 cycles. open_pulse is high for exactly 1 cycle. Release and re-press gives a second single pulse. Simultaneous open/close presses give both pulses in the same cycle.
